// File: rtl/psychic5_capture_pkg.sv
// Shared types and default raster constants for the Psychic 5 capture sequencer.
package psychic5_capture_pkg;

    // Capture sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } cap_state_t;

    // Default raster geometry of the visible 256x224 window
    localparam int DEF_H_START      = 269;
    localparam int DEF_H_LAST       = 140;
    localparam int DEF_V_FIRST      = 272;
    localparam int DEF_LINES        = 224;
    localparam int DEF_PIX_PER_LINE = 256;
    localparam int DEF_FIFO_DEPTH   = 8;
    localparam bit DEF_FLIP_V       = 1'b1;

    // One pixel write as it travels through the FIFO
    typedef struct packed {
        logic [15:0] addr;
        logic [11:0] data;
    } cap_entry_t;

    // Frame-buffer line slot: bottom-up order puts line 0 at the top slot
    function automatic logic [7:0] line_slot(input logic [7:0] line,
                                             input logic [7:0] last_line,
                                             input logic       flip);
        return flip ? (last_line - line) : line;
    endfunction

endpackage

// File: rtl/psychic5_capture_fifo.sv
// Show-ahead pixel FIFO: head entry is visible whenever the FIFO is not empty,
// and a push into a full FIFO is accepted when a pop happens on the same edge.
module psychic5_capture_fifo
    import psychic5_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
)(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  cap_entry_t i_din,
    output cap_entry_t o_dout,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    cap_entry_t r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    // Advance read/write pointers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Entry storage needs no reset; it is only read while the FIFO holds data
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/psychic5_capture_ctrl.sv
// Psychic 5 raster capture: arms on request, waits for the frame start pixel,
// counts 256x224 visible pixels and streams {address, RGB} writes downstream.
module psychic5_capture_ctrl
    import psychic5_capture_pkg::*;
#(
    parameter int H_START      = DEF_H_START,
    parameter int H_LAST       = DEF_H_LAST,
    parameter int V_FIRST      = DEF_V_FIRST,
    parameter int LINES        = DEF_LINES,
    parameter int PIX_PER_LINE = DEF_PIX_PER_LINE,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter bit FLIP_V       = DEF_FLIP_V
)(
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_MRST,
    input  logic        i_EMU_CLK6MPCEN_n,
    input  logic [8:0]  i_HCOUNTER,
    input  logic [8:0]  i_VCOUNTER,
    input  logic [11:0] i_VIDEODATA,
    input  logic        i_CAP_REQ,
    input  logic        i_WR_READY,
    output logic        o_WR_VALID,
    output logic [15:0] o_WR_ADDR,
    output logic [11:0] o_WR_DATA,
    output logic        o_CAP_BUSY,
    output logic        o_CAP_DONE,
    output logic        o_CAP_OVF,
    output logic [15:0] o_FRAME_CNT
);
    localparam logic [8:0] LP_H_START   = 9'(H_START);
    localparam logic [8:0] LP_H_LAST    = 9'(H_LAST);
    localparam logic [8:0] LP_V_FIRST   = 9'(V_FIRST);
    localparam logic [7:0] LP_LAST_LINE = 8'(LINES - 1);
    localparam logic [7:0] LP_LAST_X    = 8'(PIX_PER_LINE - 1);

    cap_state_t  r_state;
    logic [7:0]  r_x;
    logic [7:0]  r_line;
    logic [15:0] r_frame_cnt;
    logic        r_ovf;

    logic        w_pix;
    logic        w_start;
    logic        w_in_window;
    logic        w_cap_pixel;
    logic        w_last_pixel;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_valid;
    logic        w_push;
    logic        w_pop;
    cap_entry_t  w_din;
    cap_entry_t  w_head;

    assign w_pix       = ~i_EMU_CLK6MPCEN_n;
    assign w_start     = w_pix && (i_VCOUNTER == LP_V_FIRST) && (i_HCOUNTER == LP_H_START);
    // The visible line straddles the 511->128 counter wrap
    assign w_in_window = (i_HCOUNTER >= LP_H_START) || (i_HCOUNTER <= LP_H_LAST);
    // The start pixel itself is captured on the ARMED->CAPTURE edge
    assign w_cap_pixel = ((r_state == ST_ARMED) && w_start) ||
                         ((r_state == ST_CAPTURE) && w_pix && w_in_window);
    assign w_last_pixel = (r_x == LP_LAST_X) && (r_line == LP_LAST_LINE);

    assign w_valid = ~w_fifo_empty;
    assign w_pop   = w_valid && i_WR_READY;
    assign w_push  = w_cap_pixel && (!w_fifo_full || w_pop);

    assign w_din.addr = {line_slot(r_line, LP_LAST_LINE, FLIP_V), r_x};
    assign w_din.data = i_VIDEODATA;

    psychic5_capture_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_EMU_MCLK),
        .i_rst   (i_EMU_MRST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Sequencer: IDLE -> ARMED -> CAPTURE -> DRAIN -> DONE -> IDLE
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
        if (i_EMU_MRST) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_CAP_REQ) r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_cap_pixel) r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (w_cap_pixel && w_last_pixel) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_fifo_empty) begin
                        r_state     <= ST_DONE;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pixel position counters; they advance on every window pixel even if it is dropped
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
        if (i_EMU_MRST) begin
            r_x    <= '0;
            r_line <= '0;
        end else if ((r_state == ST_IDLE) && i_CAP_REQ) begin
            r_x    <= '0;
            r_line <= '0;
        end else if (w_cap_pixel) begin
            if (r_x == LP_LAST_X) begin
                r_x    <= '0;
                r_line <= r_line + 8'd1;
            end else begin
                r_x <= r_x + 8'd1;
            end
        end
    end

    // Sticky overflow flag, cleared when a new capture is requested
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
        if (i_EMU_MRST) begin
            r_ovf <= 1'b0;
        end else if ((r_state == ST_IDLE) && i_CAP_REQ) begin
            r_ovf <= 1'b0;
        end else if (w_cap_pixel && !w_push) begin
            r_ovf <= 1'b1;
        end
    end

    // Head is zeroed while empty so outputs read 0 out of reset
    assign o_WR_VALID  = w_valid;
    assign o_WR_ADDR   = w_valid ? w_head.addr : 16'd0;
    assign o_WR_DATA   = w_valid ? w_head.data : 12'd0;
    assign o_CAP_BUSY  = (r_state != ST_IDLE);
    assign o_CAP_DONE  = (r_state == ST_DONE);
    assign o_CAP_OVF   = r_ovf;
    assign o_FRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_psychic5_capture_ctrl.sv
// Bench for psychic5_capture_ctrl: three instances (full-size bottom-up,
// full-size top-down, 4-line bottom-up) driven by one bench-generated raster.
module tb_psychic5_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcen_n;
    logic [8:0]  hc;
    logic [8:0]  vc;
    logic [11:0] vd;
    logic [2:0]  req;
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  ovf;
    logic [15:0] addr [3];
    logic [11:0] data [3];
    logic [15:0] fcnt [3];

    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_k    [3];
    int          wr_base [3];
    int          done_n  [3];
    logic [15:0] first_a [3];
    logic [15:0] last_a  [3];

    typedef struct {
        int          rmode;      // 0: ready high, 1: ready low during capture, 2: ready low for first 8 pixels
        bit          spam;       // hold request high during capture, drain and done
        bit          pre400;     // request lands at V=400, well before the frame start
        int          exp_writes;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    psychic5_capture_ctrl u_dut_a (
        .i_EMU_MCLK(clk), .i_EMU_MRST(rst), .i_EMU_CLK6MPCEN_n(pcen_n),
        .i_HCOUNTER(hc), .i_VCOUNTER(vc), .i_VIDEODATA(vd),
        .i_CAP_REQ(req[0]), .i_WR_READY(rdy[0]),
        .o_WR_VALID(vld[0]), .o_WR_ADDR(addr[0]), .o_WR_DATA(data[0]),
        .o_CAP_BUSY(busy[0]), .o_CAP_DONE(done[0]), .o_CAP_OVF(ovf[0]),
        .o_FRAME_CNT(fcnt[0])
    );

    psychic5_capture_ctrl #(.FLIP_V(1'b0)) u_dut_b (
        .i_EMU_MCLK(clk), .i_EMU_MRST(rst), .i_EMU_CLK6MPCEN_n(pcen_n),
        .i_HCOUNTER(hc), .i_VCOUNTER(vc), .i_VIDEODATA(vd),
        .i_CAP_REQ(req[1]), .i_WR_READY(rdy[1]),
        .o_WR_VALID(vld[1]), .o_WR_ADDR(addr[1]), .o_WR_DATA(data[1]),
        .o_CAP_BUSY(busy[1]), .o_CAP_DONE(done[1]), .o_CAP_OVF(ovf[1]),
        .o_FRAME_CNT(fcnt[1])
    );

    psychic5_capture_ctrl #(.LINES(4)) u_dut_c (
        .i_EMU_MCLK(clk), .i_EMU_MRST(rst), .i_EMU_CLK6MPCEN_n(pcen_n),
        .i_HCOUNTER(hc), .i_VCOUNTER(vc), .i_VIDEODATA(vd),
        .i_CAP_REQ(req[2]), .i_WR_READY(rdy[2]),
        .o_WR_VALID(vld[2]), .o_WR_ADDR(addr[2]), .o_WR_DATA(data[2]),
        .o_CAP_BUSY(busy[2]), .o_CAP_DONE(done[2]), .o_CAP_OVF(ovf[2]),
        .o_FRAME_CNT(fcnt[2])
    );

    // Video content is a function of the raster position
    function automatic logic [11:0] pixdata(input int l, input int x);
        return {4'(l), 8'(x)};
    endfunction

    // Expected {addr, data} of the k-th write of instance i
    function automatic logic [27:0] exp_entry(input int i, input int k);
        int l     = k / 256;
        int x     = k % 256;
        int lines = (i == 2) ? 4 : 224;
        int slot  = (i == 1) ? l : (lines - 1 - l);
        return {16'(slot * 256 + x), pixdata(l, x)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observe every accepted write and done pulse of all instances
    task automatic sample();
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) done_n[i]++;
            if (vld[i] === 1'b1 && rdy[i] === 1'b1) begin
                int k = wr_k[i] - wr_base[i];
                check($sformatf("write_dut%0d_idx%0d", i, k), {4'd0, addr[i], data[i]},
                      {4'd0, exp_entry(i, k)});
                if (k == 0) first_a[i] = addr[i];
                last_a[i] = addr[i];
                wr_k[i]++;
            end
        end
    endtask

    // Sample at the falling edge, then return 1 time unit after the rising edge
    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic blank();
        pcen_n = 1'b0; vc = 9'd100; hc = 9'd200; vd = 12'h000;
    endtask

    // One raster of nlines visible lines starting at V=272, with a gated
    // start pixel up front, a blank pixel at each line edge and one gated
    // cycle in the middle of every line.
    task automatic drive_frame(input int nlines, input int rmode, input bit spam);
        int hv;
        pcen_n = 1'b1; vc = 9'd272; hc = 9'd269; vd = 12'hFFF;
        cyc();
        for (int l = 0; l < nlines; l++) begin
            vc = 9'(272 + l);
            pcen_n = 1'b0; hc = 9'd268; vd = 12'hFFF;
            cyc();
            for (int x = 0; x < 256; x++) begin
                hv = (x < 243) ? (269 + x) : (128 + x - 243);
                hc = 9'(hv);
                if (x == 100) begin
                    pcen_n = 1'b1; vd = 12'hFFF;
                    cyc();
                    pcen_n = 1'b0;
                end
                vd = pixdata(l, x);
                if (rmode == 1) rdy[2] = 1'b0;
                else if (rmode == 2) rdy[2] = (l > 0 || x >= 8);
                if (spam) req[2] = 1'b1;
                cyc();
            end
            hc = 9'd141; vd = 12'hFFF;
            cyc();
        end
        blank();
    endtask

    task automatic wait_done(input int i, input int d0, input string nm);
        int n = 0;
        while (done_n[i] == d0 && n < 64) begin
            cyc();
            n++;
        end
        check({nm, "_done_pulse"}, 32'(done_n[i] - d0), 32'd1);
        check({nm, "_busy_done_fall"}, {30'd0, busy[i], done[i]}, 32'd0);
        for (int j = 0; j < 4; j++) cyc();
        check({nm, "_single_done"}, 32'(done_n[i] - d0), 32'd1);
    endtask

    task automatic run_vec(input int r, input vec_t v, input int exp_fc);
        string nm = $sformatf("row%0d", r);
        int d0 = done_n[2];
        wr_base[2] = wr_k[2];
        rdy[2] = (v.rmode == 0);
        check({nm, "_idle_before_req"}, {31'd0, busy[2]}, 32'd0);
        req[2] = 1'b1;
        cyc();
        req[2] = v.spam;
        check({nm, "_busy_rise"}, {31'd0, busy[2]}, 32'd1);
        check({nm, "_ovf_cleared"}, {31'd0, ovf[2]}, 32'd0);
        if (v.pre400) begin
            for (int n = 0; n < 20; n++) begin
                pcen_n = 1'b0; vc = 9'd400; hc = 9'(269 + n % 4); vd = 12'hFFF;
                cyc();
            end
            check({nm, "_no_write_at_v400"}, 32'(wr_k[2] - wr_base[2]), 32'd0);
            check({nm, "_armed_at_v400"}, {31'd0, busy[2]}, 32'd1);
        end
        drive_frame(4, v.rmode, v.spam);
        if (v.rmode == 1) begin
            for (int n = 0; n < 20; n++) cyc();
            check({nm, "_drain_hold"}, {29'd0, vld[2], busy[2], ovf[2]}, 32'd7);
            check({nm, "_head_stable"}, {4'd0, addr[2], data[2]}, {4'd0, 16'h0300, 12'h000});
            check({nm, "_no_done_in_drain"}, 32'(done_n[2] - d0), 32'd0);
            rdy[2] = 1'b1;
        end
        wait_done(2, d0, nm);
        req[2] = 1'b0;
        check({nm, "_writes"}, 32'(wr_k[2] - wr_base[2]), 32'(v.exp_writes));
        check({nm, "_first_addr"}, {16'd0, first_a[2]}, {16'd0, v.exp_first});
        check({nm, "_last_addr"}, {16'd0, last_a[2]}, {16'd0, v.exp_last});
        check({nm, "_ovf"}, {31'd0, ovf[2]}, {31'd0, v.exp_ovf});
        check({nm, "_frame_cnt"}, {16'd0, fcnt[2]}, 32'(exp_fc));
    endtask

    initial begin
        int da;
        int db;
        int dc;
        tbl[0] = '{0, 1'b0, 1'b0, 1024, 16'h0300, 16'h00FF, 1'b0};
        tbl[1] = '{1, 1'b0, 1'b0,    8, 16'h0300, 16'h0307, 1'b1};
        tbl[2] = '{2, 1'b0, 1'b0, 1024, 16'h0300, 16'h00FF, 1'b0};
        tbl[3] = '{0, 1'b1, 1'b1, 1024, 16'h0300, 16'h00FF, 1'b0};
        for (int i = 0; i < 3; i++) begin
            wr_k[i] = 0; wr_base[i] = 0; done_n[i] = 0;
            first_a[i] = '0; last_a[i] = '0;
        end
        rst = 1'b1; req = 3'b000; rdy = 3'b111;
        blank();
        cyc();
        cyc();
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_state_dut%0d", i),
                  {vld[i], busy[i], done[i], ovf[i], fcnt[i], addr[i][11:0]},
                  {4'd0, 16'd0, 12'd0});
        rst = 1'b0;
        cyc();

        // Asynchronous reset in the middle of a capture on the small instance
        wr_base[2] = wr_k[2];
        req[2] = 1'b1;
        cyc();
        req[2] = 1'b0;
        drive_frame(2, 0, 1'b0);
        pcen_n = 1'b0; vc = 9'd274; hc = 9'd269; vd = pixdata(2, 0);
        cyc();
        check("pre_reset_busy_valid", {30'd0, vld[2], busy[2]}, 32'd3);
        rst = 1'b1;
        #1;
        check("reset_mid_valid_busy", {30'd0, vld[2], busy[2]}, 32'd0);
        check("reset_mid_done_addr", {15'd0, done[2], addr[2]}, 32'd0);
        check("reset_mid_frame_cnt", {16'd0, fcnt[2]}, 32'd0);
        blank();
        cyc();
        rst = 1'b0;
        cyc();
        check("reset_mid_no_done", 32'(done_n[2]), 32'd0);
        check("reset_mid_partial_writes", 32'(wr_k[2] - wr_base[2]), 32'd512);

        // One full frame on both full-size instances
        da = done_n[0]; db = done_n[1]; dc = wr_k[2];
        wr_base[0] = wr_k[0]; wr_base[1] = wr_k[1];
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        req[0] = 1'b1; req[1] = 1'b1;
        cyc();
        req[0] = 1'b0; req[1] = 1'b0;
        check("full_busy_rise", {30'd0, busy[1], busy[0]}, 32'd3);
        drive_frame(224, 0, 1'b0);
        wait_done(0, da, "fullA");
        check("fullB_done_pulse", 32'(done_n[1] - db), 32'd1);
        check("fullB_busy_fall", {31'd0, busy[1]}, 32'd0);
        check("fullA_writes", 32'(wr_k[0] - wr_base[0]), 32'd57344);
        check("fullA_first_addr", {16'd0, first_a[0]}, 32'h0000DF00);
        check("fullA_last_addr", {16'd0, last_a[0]}, 32'h000000FF);
        check("fullA_ovf_cnt", {15'd0, ovf[0], fcnt[0]}, 32'd1);
        check("fullB_writes", 32'(wr_k[1] - wr_base[1]), 32'd57344);
        check("fullB_first_addr", {16'd0, first_a[1]}, 32'h00000000);
        check("fullB_last_addr", {16'd0, last_a[1]}, 32'h0000DFFF);
        check("fullB_ovf_cnt", {15'd0, ovf[1], fcnt[1]}, 32'd1);
        check("idle_dut_no_writes", 32'(wr_k[2] - dc), 32'd0);

        // Table-driven scenarios on the small instance
        for (int r = 0; r < 4; r++) run_vec(r, tbl[r], r + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
